// File: rtl/flag_sync_key_if.sv
// Port bundle of the keyed CDC flag: sclk-domain pulse vector, dclk-domain
// software controls and the dclk-domain status outputs.
interface flag_sync_key_if #(
    parameter int W     = 16,
    parameter int ERR_W = 8
);
    logic [W-1:0]     set_pulse;
    logic             rst_pulse;
    logic             err_clr;
    logic             flag;
    logic             match_pulse;
    logic             err_pulse;
    logic             busy;
    logic [ERR_W-1:0] err_count;

    modport master (
        output set_pulse, rst_pulse, err_clr,
        input  flag, match_pulse, err_pulse, busy, err_count
    );

    modport slave (
        input  set_pulse, rst_pulse, err_clr,
        output flag, match_pulse, err_pulse, busy, err_count
    );
endinterface

// File: rtl/flag_sync_key.sv
// Keyed CDC flag: toggle-synchronises a pulse vector from sclk into dclk, gathers it
// over a short window and sets a sticky flag when the masked word equals the key.
module flag_sync_key #(
    parameter int           W           = 16,
    parameter logic [W-1:0] KEY         = W'(16'h12AB),
    parameter logic [W-1:0] MASK        = {W{1'b1}},
    parameter int           WINDOW      = 4,
    parameter int           SYNC_STAGES = 2,
    parameter int           ERR_W       = 8
) (
    input  logic             dclk,
    input  logic             reset_n,
    input  logic             sclk,
    flag_sync_key_if.slave   bus
);
    typedef enum logic {IDLE, COLLECT} state_e;

    logic [W-1:0] toggle_q, toggle_d;
    logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
    logic [W-1:0] edge_q, edge_d;
    logic [W-1:0] sp;

    state_e           state_q, state_d;
    logic [W-1:0]     acc_q, acc_d, acc_n;
    logic [3:0]       rem_q, rem_d;
    logic             flag_q, flag_d;
    logic             match_q, match_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic             eval, hit;

    // A level toggle per bit survives the crossing where a single sclk pulse would not.
    always_comb toggle_d = toggle_q ^ bus.set_pulse;

    // NOTE: the sclk-side flops share reset_n so both ends of the crossing start at 0
    // together and no phantom edge appears after reset.
    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) toggle_q <= '0;
        else          toggle_q <= toggle_d;
    end

    always_comb begin
        sync_d[0] = toggle_q;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        edge_d = sync_q[SYNC_STAGES-1];
        sp     = sync_q[SYNC_STAGES-1] ^ edge_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge dclk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            edge_q  <= '0;
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            flag_q  <= 1'b0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            edge_q  <= edge_d;
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            flag_q  <= flag_d;
            match_q <= match_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        flag_d  = flag_q;
        match_d = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        eval    = 1'b0;
        acc_n   = acc_q | sp;

        case (state_q)
            IDLE: begin
                if (sp != '0) begin
                    if (WINDOW == 1) begin
                        eval = 1'b1;
                    end else begin
                        acc_d   = sp;
                        rem_d   = 4'(WINDOW - 1);
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                acc_d = acc_n;
                rem_d = rem_q - 4'd1;
                // Last collecting cycle: cycle WINDOW-1 counted from the first sp.
                if (rem_q == 4'd1) begin
                    eval    = 1'b1;
                    acc_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        hit = (acc_n & MASK) == (KEY & MASK);

        // Order encodes priority: a match overrides rst_pulse, err_clr overrides an increment.
        if (bus.rst_pulse) flag_d = 1'b0;
        if (eval && hit) begin
            flag_d  = 1'b1;
            match_d = 1'b1;
        end
        if (eval && !hit) begin
            err_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
        if (bus.err_clr) cnt_d = '0;
    end

    assign bus.flag        = flag_q;
    assign bus.match_pulse = match_q;
    assign bus.err_pulse   = err_q;
    assign bus.busy        = (state_q == COLLECT);
    assign bus.err_count   = cnt_q;
endmodule

// File: tb/tb_flag_sync_key.sv
// Scoreboard bench for flag_sync_key: default instance plus a masked WINDOW=1 instance;
// expected window outcomes are queued at stimulus time and popped on each strobe.
module tb_flag_sync_key;
    logic sclk = 1'b0;
    logic dclk = 1'b0;
    logic reset_n = 1'b0;

    flag_sync_key_if #(.W(16), .ERR_W(8)) bus0 ();
    flag_sync_key_if #(.W(16), .ERR_W(8)) bus1 ();

    flag_sync_key #(.W(16), .KEY(16'h12AB), .MASK(16'hFFFF), .WINDOW(4),
                    .SYNC_STAGES(2), .ERR_W(8))
        u_dut0 (.dclk(dclk), .reset_n(reset_n), .sclk(sclk), .bus(bus0));

    flag_sync_key #(.W(16), .KEY(16'h12AB), .MASK(16'hFF00), .WINDOW(1),
                    .SYNC_STAGES(2), .ERR_W(8))
        u_dut1 (.dclk(dclk), .reset_n(reset_n), .sclk(sclk), .bus(bus1));

    // sclk posedges fall on odd ns, dclk posedges on even ns, so they never coincide.
    always #5 sclk = ~sclk;
    initial begin
        #2;
        forever begin
            dclk = 1'b1; #8;
            dclk = 1'b0; #8;
        end
    end

    typedef struct packed {
        logic       is_match;
        logic       flag;
        logic [7:0] cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   errors = 0;
    int   checks = 0;
    int   dcnt = 0;
    int   t_edge = 0;
    bit   seen_busy1 = 1'b0;

    always @(posedge dclk) dcnt <= dcnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic m, input logic f, input logic [7:0] c);
        mk = '{is_match: m, flag: f, cnt: c};
    endfunction

    // Monitor: one queued expectation per strobe.
    always @(negedge dclk) begin
        if (reset_n) begin
            if (bus1.busy) seen_busy1 = 1'b1;
            if (bus0.match_pulse || bus0.err_pulse) begin
                check("dut0 strobe expected", 32'(q0.size() != 0), 32'd1);
                if (q0.size() != 0) begin
                    e0 = q0.pop_front();
                    check("dut0 strobe kind", 32'(bus0.match_pulse), 32'(e0.is_match));
                    check("dut0 single strobe", 32'(bus0.match_pulse & bus0.err_pulse), 32'd0);
                    check("dut0 flag", 32'(bus0.flag), 32'(e0.flag));
                    check("dut0 err_count", 32'(bus0.err_count), 32'(e0.cnt));
                end
            end
            if (bus1.match_pulse || bus1.err_pulse) begin
                check("dut1 strobe expected", 32'(q1.size() != 0), 32'd1);
                if (q1.size() != 0) begin
                    e1 = q1.pop_front();
                    check("dut1 strobe kind", 32'(bus1.match_pulse), 32'(e1.is_match));
                    check("dut1 flag", 32'(bus1.flag), 32'(e1.flag));
                    check("dut1 err_count", 32'(bus1.err_count), 32'(e1.cnt));
                end
            end
        end
    end

    task automatic pulse(input int sel, input logic [15:0] bits);
        @(negedge sclk);
        if (sel == 0) bus0.set_pulse = bits;
        else          bus1.set_pulse = bits;
        @(posedge sclk);
        t_edge = dcnt;
        @(negedge sclk);
        bus0.set_pulse = '0;
        bus1.set_pulse = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge dclk);
    endtask

    task automatic wait_strobe(input int sel, input int budget, output int lat);
        bit got = 1'b0;
        lat = -1;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge dclk);
            if (sel == 0) got = bus0.match_pulse || bus0.err_pulse;
            else          got = bus1.match_pulse || bus1.err_pulse;
        end
        if (got) lat = dcnt - t_edge;
        check("strobe within budget", 32'(got), 32'd1);
    endtask

    task automatic wait_busy0(input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge dclk);
            got = bus0.busy;
        end
        check("busy within budget", 32'(got), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bus0.set_pulse = '0; bus0.rst_pulse = 1'b0; bus0.err_clr = 1'b0;
        bus1.set_pulse = '0; bus1.rst_pulse = 1'b0; bus1.err_clr = 1'b0;
        #1;
        check("reset flag",        32'(bus0.flag), 32'd0);
        check("reset match_pulse", 32'(bus0.match_pulse), 32'd0);
        check("reset err_pulse",   32'(bus0.err_pulse), 32'd0);
        check("reset busy",        32'(bus0.busy), 32'd0);
        check("reset err_count",   32'(bus0.err_count), 32'd0);
        check("reset dut1 flag",   32'(bus1.flag), 32'd0);
        repeat (3) @(negedge dclk);
        #2 reset_n = 1'b1;
        idle(4);

        // Full key on one sclk edge.
        q0.push_back(mk(1'b1, 1'b1, 8'd0));
        pulse(0, 16'h12AB);
        wait_strobe(0, 20, lat);
        check("key latency 6..7", 32'(lat >= 6 && lat <= 7), 32'd1);
        idle(6);

        // Key spread over three dclk cycles: one window.
        q0.push_back(mk(1'b1, 1'b1, 8'd0));
        pulse(0, 16'h1200);
        pulse(0, 16'h00A0);
        pulse(0, 16'h000B);
        idle(10);

        // Isolated rst_pulse.
        check("flag set before rst", 32'(bus0.flag), 32'd1);
        @(negedge dclk) bus0.rst_pulse = 1'b1;
        @(negedge dclk) bus0.rst_pulse = 1'b0;
        check("flag cleared by rst", 32'(bus0.flag), 32'd0);

        // Key spread beyond the window: two mismatching windows.
        q0.push_back(mk(1'b0, 1'b0, 8'd1));
        q0.push_back(mk(1'b0, 1'b0, 8'd2));
        pulse(0, 16'h1200);
        repeat (6) @(posedge dclk);
        pulse(0, 16'h00AB);
        idle(10);
        check("split key flag", 32'(bus0.flag), 32'd0);

        // err_clr coincident with a mismatch evaluation.
        q0.push_back(mk(1'b0, 1'b0, 8'd0));
        pulse(0, 16'h12AA);
        wait_busy0(20);
        repeat (2) @(negedge dclk);
        bus0.err_clr = 1'b1;
        @(negedge dclk) bus0.err_clr = 1'b0;
        idle(6);

        // Mismatch count up to saturation.
        for (int n = 1; n <= 301; n++) begin
            q0.push_back(mk(1'b0, 1'b0, (n > 255) ? 8'd255 : 8'(n)));
            pulse(0, 16'h12AA);
            repeat (8) @(posedge dclk);
        end
        idle(10);
        check("err_count saturated", 32'(bus0.err_count), 32'd255);

        // rst_pulse coincident with a match evaluation while flag=1.
        q0.push_back(mk(1'b1, 1'b1, 8'd255));
        pulse(0, 16'h12AB);
        idle(10);
        q0.push_back(mk(1'b1, 1'b1, 8'd255));
        pulse(0, 16'h12AB);
        wait_busy0(20);
        repeat (2) @(negedge dclk);
        bus0.rst_pulse = 1'b1;
        @(negedge dclk) bus0.rst_pulse = 1'b0;
        idle(6);
        check("set wins over rst", 32'(bus0.flag), 32'd1);

        // Reset mid-window with acc=16'h1200.
        pulse(0, 16'h1200);
        wait_busy0(20);
        #2 reset_n = 1'b0;
        #1;
        check("midreset flag",      32'(bus0.flag), 32'd0);
        check("midreset busy",      32'(bus0.busy), 32'd0);
        check("midreset err_count", 32'(bus0.err_count), 32'd0);
        check("midreset strobes",   32'(bus0.match_pulse | bus0.err_pulse), 32'd0);
        @(negedge dclk);
        #2 reset_n = 1'b1;
        idle(4);
        check("no spurious busy", 32'(bus0.busy), 32'd0);
        // 16'h00AB alone would match only if 16'h1200 survived the reset.
        q0.push_back(mk(1'b0, 1'b0, 8'd1));
        pulse(0, 16'h00AB);
        idle(10);
        q0.push_back(mk(1'b1, 1'b1, 8'd1));
        pulse(0, 16'h12AB);
        idle(10);

        // Masked instance, WINDOW=1.
        seen_busy1 = 1'b0;
        q1.push_back(mk(1'b1, 1'b1, 8'd0));
        pulse(1, 16'h1200);
        wait_strobe(1, 20, lat);
        check("window1 latency 3..4", 32'(lat >= 3 && lat <= 4), 32'd1);
        idle(6);
        q1.push_back(mk(1'b0, 1'b1, 8'd1));
        pulse(1, 16'h1300);
        idle(8);
        q1.push_back(mk(1'b1, 1'b1, 8'd1));
        pulse(1, 16'h12FF);
        idle(8);
        check("window1 never busy", 32'(seen_busy1), 32'd0);

        idle(20);
        check("dut0 queue drained", 32'(q0.size()), 32'd0);
        check("dut1 queue drained", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
